// File: rtl/dds_playback_sequencer_pkg.sv
// Shared definitions for the DDS playback sequencer.
// Holds the FSM state encoding, the default field widths and the default
// run configuration used by integrators that tie the config inputs off.
package dds_playback_sequencer_pkg;

  localparam int DEF_ADDR_W   = 17;
  localparam int DEF_DATA_W   = 11;
  localparam int DEF_PERIOD_W = 16;
  localparam int DEF_LOOP_W   = 8;

  localparam int DEFAULT_PERIOD   = 10;
  localparam int DEFAULT_END_ADDR = 66583;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

endpackage

// File: rtl/dds_playback_sequencer_step_timer.sv
// dds_step_timer: hold counter that paces the sequencer address.
// Ports:
//   clk, reset     clock and asynchronous active-low reset
//   load           restart the hold count at 0 (first cycle of a run follows)
//   enable         count while the sequencer is running
//   period_max     last hold count value, i.e. P-1
//   step           high during the last hold cycle of the current address
module dds_step_timer #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period_max,
  output logic                step
);

  logic [PERIOD_W-1:0] count_r;

  // Last-hold-cycle strobe, only meaningful while counting.
  always_comb begin
    if (enable) begin
      step = (count_r == period_max);
    end else begin
      step = 1'b0;
    end
  end

  // Hold counter: 0..P-1, restarted by load and after every step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {PERIOD_W{1'b0}};
    end else if (load) begin
      count_r <= {PERIOD_W{1'b0}};
    end else if (enable) begin
      if (step) begin
        count_r <= {PERIOD_W{1'b0}};
      end else begin
        count_r <= count_r + PERIOD_W'(1);
      end
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/dds_playback_sequencer.sv
// dds_playback_sequencer: run controller for the channel A/B DDS ROMs.
// Steps a shared address 0..end_addr, holding each for `period` clocks,
// for `loop_count` passes (0 = until abort), captures the 1-cycle-latency
// ROM words and strobes data_valid once per address step.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   start, abort          run control (abort wins, any state)
//   period/end_addr/loop_count  run configuration, latched on start
//   mem_addr, mem_en      ROM address and enable
//   douta, doutb          ROM words
//   dataa, datab, data_valid    captured words and update strobe
//   busy, done            run status, done is a 1-cycle completion pulse
module dds_playback_sequencer
  import dds_playback_sequencer_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int PERIOD_W = DEF_PERIOD_W,
  parameter int LOOP_W   = DEF_LOOP_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [PERIOD_W-1:0] period,
  input  logic [ADDR_W-1:0]   end_addr,
  input  logic [LOOP_W-1:0]   loop_count,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_en,
  input  logic [DATA_W-1:0]   douta,
  input  logic [DATA_W-1:0]   doutb,
  output logic [DATA_W-1:0]   dataa,
  output logic [DATA_W-1:0]   datab,
  output logic                data_valid,
  output logic                busy,
  output logic                done
);

  seq_state_e          state_r;
  logic [PERIOD_W-1:0] period_r;     // effective P, never 0 once latched
  logic [ADDR_W-1:0]   end_addr_r;
  logic [LOOP_W-1:0]   loop_count_r;
  logic [LOOP_W-1:0]   pass_r;
  logic                drain_r;      // second DRAIN cycle marker
  logic [1:0]          pipe_r;       // address-change -> ROM -> capture
  logic                step_s;
  logic                launch_s;
  logic                last_addr_s;
  logic                last_pass_s;
  logic [PERIOD_W-1:0] period_max_s;

  // Decodes for run launch and end-of-pass / end-of-run conditions.
  always_comb begin
    launch_s     = (state_r == ST_IDLE) && start && !abort;
    period_max_s = period_r - PERIOD_W'(1);
    last_addr_s  = (mem_addr == end_addr_r);
    if (loop_count_r != {LOOP_W{1'b0}}) begin
      last_pass_s = (pass_r == (loop_count_r - LOOP_W'(1)));
    end else begin
      last_pass_s = 1'b0;
    end
  end

  dds_step_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_step_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (launch_s),
    .enable     (state_r == ST_RUN),
    .period_max (period_max_s),
    .step       (step_s)
  );

  // Sequencer FSM, address/pass counters and the valid/capture pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      period_r     <= {PERIOD_W{1'b0}};
      end_addr_r   <= {ADDR_W{1'b0}};
      loop_count_r <= {LOOP_W{1'b0}};
      pass_r       <= {LOOP_W{1'b0}};
      drain_r      <= 1'b0;
      pipe_r       <= 2'b00;
      mem_addr     <= {ADDR_W{1'b0}};
      mem_en       <= 1'b0;
      dataa        <= {DATA_W{1'b0}};
      datab        <= {DATA_W{1'b0}};
      data_valid   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else if (abort) begin
      // Pipeline is flushed so no stale strobe follows an abort;
      // dataa/datab keep their last value.
      state_r    <= ST_IDLE;
      pass_r     <= {LOOP_W{1'b0}};
      drain_r    <= 1'b0;
      pipe_r     <= 2'b00;
      mem_addr   <= {ADDR_W{1'b0}};
      mem_en     <= 1'b0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done       <= 1'b0;
      data_valid <= pipe_r[1];
      if (pipe_r[1]) begin
        dataa <= douta;
        datab <= doutb;
      end else begin
        dataa <= dataa;
        datab <= datab;
      end
      // pipe_r[0] marks the first cycle of a new address; the ROM word for
      // it is available one cycle later and captured on the following edge.
      pipe_r <= {pipe_r[0], 1'b0};
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r      <= ST_RUN;
            period_r     <= (period == {PERIOD_W{1'b0}}) ? PERIOD_W'(1) : period;
            end_addr_r   <= end_addr;
            loop_count_r <= loop_count;
            pass_r       <= {LOOP_W{1'b0}};
            mem_addr     <= {ADDR_W{1'b0}};
            mem_en       <= 1'b1;
            busy         <= 1'b1;
            pipe_r       <= {pipe_r[0], 1'b1};
          end
        end
        ST_RUN: begin
          if (step_s) begin
            if (last_addr_s) begin
              mem_addr <= {ADDR_W{1'b0}};
              if (last_pass_s) begin
                state_r <= ST_DRAIN;
                drain_r <= 1'b0;
              end else begin
                pass_r <= pass_r + LOOP_W'(1);
                pipe_r <= {pipe_r[0], 1'b1};
              end
            end else begin
              mem_addr <= mem_addr + ADDR_W'(1);
              pipe_r   <= {pipe_r[0], 1'b1};
            end
          end
        end
        ST_DRAIN: begin
          if (drain_r) begin
            state_r  <= ST_IDLE;
            drain_r  <= 1'b0;
            mem_addr <= {ADDR_W{1'b0}};
            mem_en   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else begin
            drain_r <= 1'b1;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          drain_r  <= 1'b0;
          pipe_r   <= 2'b00;
          mem_addr <= {ADDR_W{1'b0}};
          mem_en   <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_playback_sequencer.sv
// Self-checking bench for dds_playback_sequencer with a behavioural ROM and
// a cycle-index reference model derived from the run parameters.
module tb_dds_playback_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] period;
  logic [16:0] end_addr;
  logic [7:0]  loop_count;
  logic [16:0] mem_addr;
  logic        mem_en;
  logic [10:0] douta;
  logic [10:0] doutb;
  logic [10:0] dataa;
  logic [10:0] datab;
  logic        data_valid;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [10:0] exp_a = 11'd0;
  logic [10:0] exp_b = 11'd0;

  dds_playback_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .period     (period),
    .end_addr   (end_addr),
    .loop_count (loop_count),
    .mem_addr   (mem_addr),
    .mem_en     (mem_en),
    .douta      (douta),
    .doutb      (doutb),
    .dataa      (dataa),
    .datab      (datab),
    .data_valid (data_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] rom_a(input int a);
    rom_a = 11'((a * 37 + 113) ^ (a >> 2));
  endfunction

  function automatic logic [10:0] rom_b(input int a);
    rom_b = 11'((a * 91 + 7) ^ 1365);
  endfunction

  // Behavioural ROM pair, one clock of read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      douta <= rom_a(int'(mem_addr));
      doutb <= rom_b(int'(mem_addr));
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, " busy"}, 32'(busy), 32'd0);
    check_eq({tag, " mem_en"}, 32'(mem_en), 32'd0);
    check_eq({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
    check_eq({tag, " done"}, 32'(done), 32'd0);
    check_eq({tag, " data_valid"}, 32'(data_valid), 32'd0);
    check_eq({tag, " dataa"}, 32'(dataa), 32'(exp_a));
    check_eq({tag, " datab"}, 32'(datab), 32'(exp_b));
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      check_idle(tag);
    end
  endtask

  // One run. Cycle k=1 is the first RUN cycle. abort_at/rst_at > 0 end the
  // run in that cycle; restart_at > 0 pulses start with new config there.
  task automatic run_case(input string tag, input int p_in, input int e_in, input int l_in,
                          input int abort_at, input int restart_at, input int rst_at);
    int p;
    int total;
    int steps;
    int last;
    int a;
    int si;
    bit dv;
    p = (p_in == 0) ? 1 : p_in;
    total = p * (e_in + 1) * l_in;
    steps = (e_in + 1) * l_in;
    if (abort_at > 0) last = abort_at;
    else if (rst_at > 0) last = rst_at;
    else last = total + 3;

    period = 16'(p_in);
    end_addr = 17'(e_in);
    loop_count = 8'(l_in);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    period = 16'($urandom);
    end_addr = 17'($urandom);
    loop_count = 8'($urandom);

    for (int k = 1; k <= last; k++) begin
      start = 1'b0;
      abort = 1'b0;
      si = (k - 3) / p;
      dv = (k >= 3) && (((k - 3) % p) == 0) && ((l_in == 0) || (si < steps));
      if (dv) begin
        exp_a = rom_a(si % (e_in + 1));
        exp_b = rom_b(si % (e_in + 1));
      end
      if ((l_in == 0) || (k <= total)) begin
        a = ((k - 1) / p) % (e_in + 1);
        check_eq({tag, " mem_addr"}, 32'(mem_addr), 32'(a));
      end
      if ((l_in != 0) && (k == total + 3)) begin
        check_eq({tag, " done"}, 32'(done), 32'd1);
        check_eq({tag, " busy end"}, 32'(busy), 32'd0);
        check_eq({tag, " mem_en end"}, 32'(mem_en), 32'd0);
      end else begin
        check_eq({tag, " done"}, 32'(done), 32'd0);
        check_eq({tag, " busy"}, 32'(busy), 32'd1);
        check_eq({tag, " mem_en"}, 32'(mem_en), 32'd1);
      end
      check_eq({tag, " data_valid"}, 32'(data_valid), 32'(dv));
      check_eq({tag, " dataa"}, 32'(dataa), 32'(exp_a));
      check_eq({tag, " datab"}, 32'(datab), 32'(exp_b));
      if (k == restart_at) begin
        start = 1'b1;
        period = 16'($urandom_range(1, 9));
        end_addr = 17'($urandom_range(0, 9));
        loop_count = 8'($urandom_range(1, 4));
      end
      if (k < last) begin
        @(posedge clk); #1;
      end
    end

    if (abort_at > 0) begin
      abort = 1'b1;
      idle_cycles({tag, " post-abort"}, 5);
    end else if (rst_at > 0) begin
      reset = 1'b0;
      #1;
      exp_a = 11'd0;
      exp_b = 11'd0;
      check_idle({tag, " in-reset"});
      @(posedge clk); #1;
      reset = 1'b1;
      idle_cycles({tag, " post-reset"}, 3);
    end else begin
      idle_cycles({tag, " post-done"}, 3);
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b1;
    abort = 1'b0;
    period = 16'd10;
    end_addr = 17'd3;
    loop_count = 8'd1;

    // Reset held with start asserted: nothing moves.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_idle("reset");
    end
    start = 1'b0;
    reset = 1'b1;
    idle_cycles("after reset", 2);

    run_case("p10e3l1", 10, 3, 1, 0, 0, 0);
    run_case("p0e2l2", 0, 2, 2, 0, 0, 0);
    run_case("loop0 abort", 4, 5, 0, 50, 0, 0);
    run_case("restart ignored", 6, 3, 2, 0, 5, 0);

    // Start and abort together in IDLE: abort wins.
    start = 1'b1;
    abort = 1'b1;
    period = 16'd2;
    end_addr = 17'd1;
    loop_count = 8'd1;
    idle_cycles("start+abort", 3);

    // Reset asserted in the first DRAIN cycle (T+1 = 3*3*1+1).
    run_case("reset in drain", 3, 2, 1, 0, 0, 10);
    run_case("e0 single", 5, 0, 3, 0, 0, 0);
    run_case("p1 finite", 1, 4, 1, 0, 0, 0);

    for (int r = 0; r < 6; r++) begin
      run_case($sformatf("rand%0d", r), int'($urandom_range(0, 5)),
               int'($urandom_range(0, 6)), int'($urandom_range(1, 3)), 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
